// File: rtl/fifo_rd_stream_adapter_if.sv
// Read-side bundle between the async FIFO controller/RAM port and the rclk stream adapter.
// master = adapter side, slave = FIFO controller / downstream side.
interface fifo_rd_stream_adapter_if #(
  parameter int DSIZE = 8
);
  logic             rempty;
  logic             rd_req_n;
  logic [DSIZE-1:0] rdata;
  logic [DSIZE-1:0] dout;
  logic             dout_valid;
  logic             dout_ready;
  logic [2:0]       level;

  modport master (
    input  rempty, rdata, dout_ready,
    output rd_req_n, dout, dout_valid, level
  );

  modport slave (
    output rempty, rdata, dout_ready,
    input  rd_req_n, dout, dout_valid, level
  );
endinterface

// File: rtl/fifo_rd_stream_adapter.sv
// Credit-based FIFO read consumer feeding a first-word-fall-through skid buffer (rclk domain).
// Optional FIFO_RD_CNT_EN adds the rd_cnt transfer counter and the sticky req_empty_seen flag.
module fifo_rd_stream_adapter #(
  parameter int DSIZE  = 8,
  parameter int RD_LAT = 1    // RAM read latency, 1 or 2
) (
  input  logic rclk,
  input  logic rrst_n,
  input  logic r_clr,
  fifo_rd_stream_adapter_if.master bus
`ifdef FIFO_RD_CNT_EN
  ,
  output logic [15:0] rd_cnt,
  output logic        req_empty_seen
`endif
);
  localparam int SKID = RD_LAT + 2;
  localparam int PW   = $clog2(SKID);
  // The fire cycle itself is the first latency stage, so only RD_LAT-1 flags are registered.
  localparam int IW   = (RD_LAT > 1) ? RD_LAT - 1 : 1;
  localparam logic [2:0]    SKID_L   = 3'(SKID);
  localparam logic [PW-1:0] PTR_LAST = PW'(SKID - 1);

  typedef logic [DSIZE-1:0] word_t;

  logic [2:0]    occ_q, occ_d, inflight;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [IW-1:0] infl_q, infl_d;
  word_t         mem_q [SKID];
  word_t         mem_d [SKID];
  logic          want, fire, push, pop, valid;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PW'(1);
  endfunction

  always_comb begin
    inflight = '0;
    for (int i = 0; i < IW; i++) inflight = inflight + 3'(infl_q[i]);
  end

  // Credit excludes this cycle's pop, so dout_ready never reaches rd_req_n.
  assign valid = (occ_q != '0);
  assign want  = ~r_clr & ((occ_q + inflight) < SKID_L);
  assign fire  = want & ~bus.rempty;
  assign push  = (RD_LAT == 1) ? fire : infl_q[IW-1];
  assign pop   = valid & bus.dout_ready;

  assign bus.rd_req_n   = ~fire;
  assign bus.dout_valid = valid;
  assign bus.dout       = mem_q[rd_ptr_q];
  assign bus.level      = occ_q;

  // NOTE: every always_comb output gets a default first, so no branch can infer a latch.
  always_comb begin
    occ_d    = occ_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    mem_d    = mem_q;
    infl_d   = (RD_LAT == 1) ? '0 : ((infl_q << 1) | IW'(fire));
    if (r_clr) begin
      occ_d    = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      infl_d   = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = bus.rdata;
        wr_ptr_d        = ptr_inc(wr_ptr_q);
      end
      if (pop) rd_ptr_d = ptr_inc(rd_ptr_q);
      case ({push, pop})
        2'b10:   occ_d = occ_q + 3'd1;
        2'b01:   occ_d = occ_q - 3'd1;
        default: occ_d = occ_q;
      endcase
    end
  end

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      occ_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      infl_q   <= '0;
      // NOTE: the storage is only SKID words, so it is reset to make dout read 0 out of reset.
      for (int i = 0; i < SKID; i++) mem_q[i] <= '0;
    end else begin
      // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
      occ_q    <= occ_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      infl_q   <= infl_d;
      mem_q    <= mem_d;
    end
  end

  credit_ok: assert property (@(posedge rclk) disable iff (!rrst_n)
                              (occ_q + inflight) <= SKID_L)
    else $error("skid buffer credit exceeded");

`ifdef FIFO_RD_CNT_EN
  logic [15:0] rd_cnt_q, rd_cnt_d;
  logic        seen_q, seen_d;

  // "Would have fired": credit available and no clear, but the FIFO reports empty.
  always_comb begin
    rd_cnt_d = rd_cnt_q + 16'(pop);
    seen_d   = seen_q | (want & bus.rempty);
    if (r_clr) begin
      rd_cnt_d = '0;
      seen_d   = 1'b0;
    end
  end

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      rd_cnt_q <= '0;
      seen_q   <= 1'b0;
    end else begin
      rd_cnt_q <= rd_cnt_d;
      seen_q   <= seen_d;
    end
  end

  assign rd_cnt         = rd_cnt_q;
  assign req_empty_seen = seen_q;
`endif
endmodule

// File: tb/tb_fifo_rd_stream_adapter.sv
// Bench for fifo_rd_stream_adapter: two lanes (RD_LAT=1 and RD_LAT=2) share stimulus, each with a
// behavioural FIFO/RAM model and a scoreboard queue popped by a per-lane stream monitor.
module tb_fifo_rd_stream_adapter;
  logic       rclk = 1'b0;
  logic       rrst_n = 1'b0;
  logic       r_clr = 1'b0;
  logic       dout_ready = 1'b0;
  logic       wr_en = 1'b0;
  logic [7:0] wr_data = '0;
  int         total = 0;
  int         bad = 0;

  always #5 rclk = ~rclk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : lane
    localparam int LAT  = g + 1;
    localparam int SKID = LAT + 2;

    fifo_rd_stream_adapter_if #(.DSIZE(8)) bus ();
    logic [7:0] fmem [256];
    logic [7:0] wcnt, rcnt, rd_pipe;
    logic       rempty_q;
    logic       fire;
    logic [7:0] exp_q [$];
    int         n_exp = 0;
    logic       hold = 1'b0;
    logic [7:0] last_dout = '0;
`ifdef FIFO_RD_CNT_EN
    logic [15:0] rd_cnt;
    logic        req_empty_seen;
`endif

    assign fire           = ~bus.rd_req_n & ~rempty_q;
    assign bus.rempty     = rempty_q;
    assign bus.rdata      = (LAT == 1) ? fmem[rcnt] : rd_pipe;
    assign bus.dout_ready = dout_ready;

    fifo_rd_stream_adapter #(.DSIZE(8), .RD_LAT(LAT)) dut (
      .rclk   (rclk),
      .rrst_n (rrst_n),
      .r_clr  (r_clr),
      .bus    (bus)
`ifdef FIFO_RD_CNT_EN
      ,
      .rd_cnt         (rd_cnt),
      .req_empty_seen (req_empty_seen)
`endif
    );

    // FIFO controller + RAM model; every accepted write is also the expected stream word.
    always @(posedge rclk or negedge rrst_n) begin
      if (!rrst_n || r_clr) begin
        wcnt     <= '0;
        rcnt     <= '0;
        rd_pipe  <= '0;
        rempty_q <= 1'b1;
        exp_q.delete();
      end else begin
        if (wr_en) begin
          fmem[wcnt] <= wr_data;
          exp_q.push_back(wr_data);
        end
        wcnt     <= wcnt + 8'(wr_en);
        rcnt     <= rcnt + 8'(fire);
        rempty_q <= ((wcnt + 8'(wr_en)) == (rcnt + 8'(fire)));
        rd_pipe  <= fmem[rcnt];
      end
    end

    // Stream monitor
    always @(negedge rclk) begin
      if (!rrst_n) begin
        hold = 1'b0;
      end else begin
        if (hold) begin
          check($sformatf("hold_valid%0d", g), bus.dout_valid, 1);
          check($sformatf("hold_data%0d", g), bus.dout, last_dout);
        end
        if (bus.dout_valid && dout_ready) begin
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL extra_word%0d: got %0h want nothing", g, bus.dout);
          end else begin
            check($sformatf("order%0d", g), bus.dout, exp_q.pop_front());
          end
        end
        check($sformatf("credit%0d", g), bus.level <= SKID, 1);
        hold      = bus.dout_valid && !dout_ready && !r_clr;
        last_dout = bus.dout;
        n_exp     = exp_q.size();
      end
    end
  end

  task automatic tick();
    @(posedge rclk);
    #1;
  endtask

  task automatic write_words(input int n, input logic [7:0] base);
    for (int i = 0; i < n; i++) begin
      wr_en   = 1'b1;
      wr_data = base + 8'(i);
      tick();
    end
    wr_en = 1'b0;
  endtask

  task automatic clear();
    r_clr = 1'b1;
    tick();
    r_clr = 1'b0;
  endtask

  task automatic drain();
    dout_ready = 1'b1;
    for (int i = 0; i < 400 && (lane[0].n_exp != 0 || lane[1].n_exp != 0); i++) tick();
    tick();
    check("drain0", lane[0].n_exp, 0);
    check("drain1", lane[1].n_exp, 0);
    @(negedge rclk);
    check("idle_valid0", lane[0].bus.dout_valid, 0);
    check("idle_valid1", lane[1].bus.dout_valid, 0);
    tick();
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_req0"}, lane[0].bus.rd_req_n, 1);
    check({tag, "_req1"}, lane[1].bus.rd_req_n, 1);
    check({tag, "_valid0"}, lane[0].bus.dout_valid, 0);
    check({tag, "_valid1"}, lane[1].bus.dout_valid, 0);
    check({tag, "_dout0"}, lane[0].bus.dout, 0);
    check({tag, "_dout1"}, lane[1].bus.dout, 0);
    check({tag, "_level0"}, lane[0].bus.level, 0);
    check({tag, "_level1"}, lane[1].bus.level, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge rclk);
    #1;
    check_reset_vals("rst");
`ifdef FIFO_RD_CNT_EN
    check("rst_cnt0", lane[0].rd_cnt, 0);
    check("rst_seen0", lane[0].req_empty_seen, 0);
`endif
    rrst_n = 1'b1;
    tick();

    // Single word: RD_LAT=1 valid after T+1, RD_LAT=2 after T+2
    dout_ready = 1'b1;
    wr_en      = 1'b1;
    wr_data    = 8'hA5;
    @(posedge rclk);
    #1;
    wr_en = 1'b0;
    @(negedge rclk);
    check("t1_req0", lane[0].bus.rd_req_n, 0);
    check("t1_early0", lane[0].bus.dout_valid, 0);
    @(negedge rclk);
    check("t1_valid0", lane[0].bus.dout_valid, 1);
    check("t1_dout0", lane[0].bus.dout, 8'hA5);
    check("t1_early1", lane[1].bus.dout_valid, 0);
    @(negedge rclk);
    check("t1_level0", lane[0].bus.level, 0);
    check("t1_valid1", lane[1].bus.dout_valid, 1);
    check("t1_dout1", lane[1].bus.dout, 8'hA5);
    @(negedge rclk);
    check("t1_level1", lane[1].bus.level, 0);
    tick();

    // Backpressure: buffer fills to SKID, requests stop, head stays put, then drains in order
    dout_ready = 1'b0;
    write_words(8, 8'h10);
    repeat (6) tick();
    check("t3_level0", lane[0].bus.level, 3);
    check("t3_level1", lane[1].bus.level, 4);
    check("t3_req0", lane[0].bus.rd_req_n, 1);
    check("t3_req1", lane[1].bus.rd_req_n, 1);
    check("t3_head0", lane[0].bus.dout, 8'h10);
    check("t3_head1", lane[1].bus.dout, 8'h10);
    dout_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge rclk);
      check("t3_stream0", lane[0].bus.dout_valid, 1);
      check("t3_stream1", lane[1].bus.dout_valid, 1);
    end
    drain();

    // 16 preloaded words stream without gaps
    dout_ready = 1'b0;
    write_words(16, 8'h00);
    repeat (4) tick();
    dout_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      @(negedge rclk);
      check("t2_stream0", lane[0].bus.dout_valid, 1);
      check("t2_stream1", lane[1].bus.dout_valid, 1);
    end
    drain();

    // Toggling ready with 10 words
    clear();
`ifdef FIFO_RD_CNT_EN
    check("t4_cnt_clr", lane[0].rd_cnt, 0);
    check("t4_seen_clr", lane[1].req_empty_seen, 0);
`endif
    for (int i = 0; i < 10; i++) begin
      wr_en      = 1'b1;
      wr_data    = 8'h40 + 8'(i);
      dout_ready = (i % 2 == 0);
      tick();
    end
    wr_en = 1'b0;
    for (int i = 0; i < 60; i++) begin
      dout_ready = (i % 2 == 0);
      tick();
    end
    check("t4_left0", lane[0].n_exp, 0);
    check("t4_left1", lane[1].n_exp, 0);
`ifdef FIFO_RD_CNT_EN
    check("t4_cnt0", lane[0].rd_cnt, 10);
    check("t4_cnt1", lane[1].rd_cnt, 10);
    check("t4_seen0", lane[0].req_empty_seen, 1);
`endif
    drain();

    // Clear with level=2 and one read in flight (RD_LAT=2 lane)
    dout_ready = 1'b0;
    write_words(3, 8'h80);
    tick();
    check("t5_pre_level1", lane[1].bus.level, 2);
    clear();
    @(negedge rclk);
    check("t5_valid0", lane[0].bus.dout_valid, 0);
    check("t5_valid1", lane[1].bus.dout_valid, 0);
    check("t5_level0", lane[0].bus.level, 0);
    check("t5_level1", lane[1].bus.level, 0);
    dout_ready = 1'b1;
    repeat (6) tick();
    @(negedge rclk);
    check("t5_stale1", lane[1].bus.dout_valid, 0);
    tick();

    // Asynchronous reset in the middle of a stream
    for (int i = 0; i < 20; i++) begin
      wr_en   = 1'b1;
      wr_data = 8'hC0 + 8'(i);
      tick();
      if (i == 6) begin
        wr_en = 1'b0;
        #3 rrst_n = 1'b0;
        #1 check_reset_vals("t6");
        tick();
        tick();
        rrst_n = 1'b1;
      end
    end
    wr_en = 1'b0;
    drain();

    // Randomized traffic with occasional clears
    for (int i = 0; i < 400; i++) begin
      r_clr      = ($urandom_range(0, 199) == 0);
      wr_en      = !r_clr && ($urandom_range(0, 99) < 45);
      wr_data    = 8'($urandom);
      dout_ready = ($urandom_range(0, 99) < 65);
      tick();
    end
    r_clr = 1'b0;
    wr_en = 1'b0;
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
